// File: rtl/rr_arb4_pkg.sv
// rtl/rr_arb4_pkg.sv - shared types and sizes for the four-way round-robin arbiter
package rr_arb4_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

endpackage

// File: rtl/mux4to1.sv
// rtl/mux4to1.sv - four-input word multiplexer
//   s        : select index
//   d0..d3   : candidate words
//   y        : selected word
module mux4to1 #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = d0;
        case (s)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - circular priority pick starting after the last winner
//   req    : request vector
//   ptr    : index of the previous winner
//   winner : first set request searching ptr+1, ptr+2, ... (mod 4)
//   any    : at least one request is set
module rr_pick4
    import rr_arb4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    // Scan from the farthest offset to the nearest so the nearest hit is
    // written last; offset NUM_REQ wraps to ptr itself (lowest priority).
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[ptr + IDX_W'(k)]) begin
                winner = ptr + IDX_W'(k);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - four-way round-robin arbiter with a one-word output register
//   clk, rst_n       : clock, asynchronous active-low reset
//   req, din0..din3  : requester valids and data words
//   ack              : one-hot capture strobe for the winning requester
//   sel, dout        : registered index and word held at the output
//   dout_valid, busy : output register holds an unconsumed word
//   dout_ready       : consumer accepts dout
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [WIDTH-1:0]   din0,
    input  logic [WIDTH-1:0]   din1,
    input  logic [WIDTH-1:0]   din2,
    input  logic [WIDTH-1:0]   din3,
    output logic [3:0]         ack,
    output logic [1:0]         sel,
    output logic [WIDTH-1:0]   dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   sel_q;
    logic [WIDTH-1:0]   dout_q;
    logic [IDX_W-1:0]   winner;
    logic               any;
    logic [WIDTH-1:0]   win_word;
    logic               capture;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    mux4to1 #(.WIDTH(WIDTH)) u_mux (
        .s  (winner),
        .d0 (din0),
        .d1 (din1),
        .d2 (din2),
        .d3 (din3),
        .y  (win_word)
    );

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        ack     = '0;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    capture = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // Consume and refill in the same cycle keeps the output full.
                if (dout_ready) begin
                    if (any) begin
                        capture = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // ack must stay low during reset even though it is combinational.
        if (capture && rst_n) begin
            ack = NUM_REQ'(1) << winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dout_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            if (capture) begin
                dout_q <= win_word;
                sel_q  <= winner;
                ptr_q  <= winner;
            end
        end
    end

    assign dout       = dout_q;
    assign sel        = sel_q;
    assign dout_valid = (state_q == ST_FULL);
    assign busy       = dout_valid;

endmodule

// File: tb/tb_rr_arb4.sv
// tb/tb_rr_arb4.sv - self-checking bench for rr_arb4 with a behavioural model
module tb_rr_arb4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] din [4];
    logic       dout_ready;
    logic [3:0] ack;
    logic [1:0] sel;
    logic [7:0] dout;
    logic       dout_valid;
    logic       busy;

    rr_arb4 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din0       (din[0]),
        .din1       (din[1]),
        .din2       (din[2]),
        .din3       (din[3]),
        .ack        (ack),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // reference model state
    bit         m_valid;
    logic [7:0] m_dout;
    int         m_sel;
    int         m_ptr;
    int         m_win;

    // values sampled mid-cycle by drive()
    logic [3:0] obs_ack, exp_ack;
    logic       obs_valid;
    logic [7:0] obs_dout;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_dout  = 8'h00;
        m_sel   = 0;
        m_ptr   = 3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Apply one cycle of stimulus, sample at the falling edge, advance the model.
    task automatic drive(input logic [3:0] r, input logic rdy);
        bit cap;
        req        = r;
        dout_ready = rdy;
        @(negedge clk);
        obs_ack   = ack;
        obs_valid = dout_valid;
        obs_dout  = dout;
        m_win     = pick(r, m_ptr);
        cap       = (m_win >= 0) && (!m_valid || rdy);
        exp_ack   = cap ? (4'b0001 << m_win) : 4'b0000;
        if (!cap) m_win = -1;
        @(posedge clk);
        if (cap) begin
            m_dout  = din[m_win];
            m_sel   = m_win;
            m_ptr   = m_win;
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req        = 4'b1111;
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = 8'hFF;
        @(negedge clk);
        total_cnt++; if (ack !== 4'b0000) $display("FAIL reset_ack got=%b exp=0000", ack); else pass_cnt++;
        total_cnt++; if (dout_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", dout_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", dout); else pass_cnt++;
        total_cnt++; if (sel !== 2'd0) $display("FAIL reset_sel got=%0d exp=0", sel); else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 4'b0000;
        model_reset();
    endtask

    task automatic test_alternate();
        logic [7:0] exp_d;
        do_reset();
        din[0] = 8'h11;
        din[2] = 8'h22;
        for (int i = 0; i < 4; i++) begin
            drive(4'b0101, 1'b1);
            exp_d = (i % 2 == 0) ? 8'h11 : 8'h22;
            total_cnt++; if (obs_ack !== ((i % 2 == 0) ? 4'b0001 : 4'b0100)) $display("FAIL alt_ack[%0d] got=%b", i, obs_ack); else pass_cnt++;
            total_cnt++; if (dout !== exp_d || dout_valid !== 1'b1) $display("FAIL alt_dout[%0d] got=%h/%b exp=%h/1", i, dout, dout_valid, exp_d); else pass_cnt++;
        end
    endtask

    task automatic test_all_four();
        do_reset();
        for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 1'b1);
            total_cnt++; if (sel !== 2'(i % 4)) $display("FAIL all4_sel[%0d] got=%0d exp=%0d", i, sel, i % 4); else pass_cnt++;
            total_cnt++; if (dout_valid !== 1'b1 || dout !== din[i % 4]) $display("FAIL all4_dout[%0d] got=%h/%b exp=%h/1", i, dout, dout_valid, din[i % 4]); else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        din[1] = 8'hA5;
        drive(4'b0010, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b0);
            total_cnt++; if (obs_ack !== 4'b0000) $display("FAIL stall_ack[%0d] got=%b exp=0000", i, obs_ack); else pass_cnt++;
            total_cnt++; if (dout !== 8'hA5 || sel !== 2'd1 || dout_valid !== 1'b1) $display("FAIL stall_hold[%0d] got=%h/%0d/%b exp=a5/1/1", i, dout, sel, dout_valid); else pass_cnt++;
        end
        drive(4'b1111, 1'b1);
        total_cnt++; if (obs_ack !== 4'b0100) $display("FAIL stall_next_ack got=%b exp=0100", obs_ack); else pass_cnt++;
        total_cnt++; if (sel !== 2'd2) $display("FAIL stall_next_sel got=%0d exp=2", sel); else pass_cnt++;
    endtask

    task automatic test_drain();
        do_reset();
        din[3] = 8'h3C;
        drive(4'b1000, 1'b1);
        total_cnt++; if (sel !== 2'd3 || dout_valid !== 1'b1 || dout !== 8'h3C) $display("FAIL drain_cap got=%0d/%b/%h exp=3/1/3c", sel, dout_valid, dout); else pass_cnt++;
        drive(4'b0000, 1'b1);
        total_cnt++; if (obs_ack !== 4'b0000) $display("FAIL drain_ack got=%b exp=0000", obs_ack); else pass_cnt++;
        total_cnt++; if (dout_valid !== 1'b0 || busy !== 1'b0) $display("FAIL drain_valid got=%b/%b exp=0/0", dout_valid, busy); else pass_cnt++;
        total_cnt++; if (sel !== 2'd3 || dout !== 8'h3C) $display("FAIL drain_hold got=%0d/%h exp=3/3c", sel, dout); else pass_cnt++;
        drive(4'b1001, 1'b1);
        total_cnt++; if (obs_ack !== 4'b0001 || sel !== 2'd0) $display("FAIL drain_next got=%b/%0d exp=0001/0", obs_ack, sel); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(4'b1111, 1'b1);
        drive(4'b1111, 1'b0);
        total_cnt++; if (dout_valid !== 1'b1) $display("FAIL areset_pre got=%b exp=1", dout_valid); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (dout_valid !== 1'b0 || busy !== 1'b0) $display("FAIL areset_valid got=%b/%b exp=0/0", dout_valid, busy); else pass_cnt++;
        total_cnt++; if (ack !== 4'b0000 || dout !== 8'h00 || sel !== 2'd0) $display("FAIL areset_regs got=%b/%h/%0d exp=0000/00/0", ack, dout, sel); else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(4'b1010, 1'b1);
        total_cnt++; if (obs_ack !== 4'b0010 || sel !== 2'd1) $display("FAIL areset_first got=%b/%0d exp=0010/1", obs_ack, sel); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0] sb [$];
        logic [7:0] exp_w;
        logic [7:0] prev_dout;
        logic       prev_stall;
        int         wait_cnt [4];
        int         max_wait;
        int         errs_ack, errs_reg, errs_sb, errs_stable;
        logic [3:0] r;
        logic       rdy;
        errs_ack = 0; errs_reg = 0; errs_sb = 0; errs_stable = 0;
        max_wait = 0;
        prev_stall = 1'b0;
        prev_dout  = 8'h00;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        do_reset();
        for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
        for (int c = 0; c < 10000; c++) begin
            r   = 4'($urandom);
            rdy = ($urandom_range(3, 0) != 0);
            drive(r, rdy);
            if (obs_ack !== exp_ack) begin
                errs_ack++;
                if (errs_ack < 5) $display("FAIL rand_ack cyc=%0d got=%b exp=%b", c, obs_ack, exp_ack);
            end
            if (prev_stall && obs_dout !== prev_dout) begin
                errs_stable++;
                if (errs_stable < 5) $display("FAIL rand_stable cyc=%0d got=%h exp=%h", c, obs_dout, prev_dout);
            end
            prev_stall = obs_valid && !rdy;
            prev_dout  = obs_dout;
            if (obs_valid && rdy) begin
                if (sb.size() == 0) begin
                    errs_sb++;
                    if (errs_sb < 5) $display("FAIL rand_sb_empty cyc=%0d got=%h", c, obs_dout);
                end else begin
                    exp_w = sb.pop_front();
                    if (obs_dout !== exp_w) begin
                        errs_sb++;
                        if (errs_sb < 5) $display("FAIL rand_sb cyc=%0d got=%h exp=%h", c, obs_dout, exp_w);
                    end
                end
            end
            if (m_win >= 0) begin
                sb.push_back(din[m_win]);
                for (int i = 0; i < 4; i++) begin
                    if (i == m_win || !r[i]) wait_cnt[i] = 0;
                    else wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
            end else begin
                for (int i = 0; i < 4; i++) if (!r[i]) wait_cnt[i] = 0;
            end
            if (dout_valid !== m_valid || (m_valid && (dout !== m_dout || sel !== 2'(m_sel)))) begin
                errs_reg++;
                if (errs_reg < 5) $display("FAIL rand_regs cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", c, dout_valid, dout, sel, m_valid, m_dout, m_sel);
            end
            // din may change only when its requester is idle or was just acked
            for (int i = 0; i < 4; i++) begin
                if (!r[i] || obs_ack[i]) din[i] = 8'($urandom);
            end
            r = 4'($urandom);
        end
        total_cnt++; if (errs_ack != 0) $display("FAIL rand_ack_total got=%0d exp=0", errs_ack); else pass_cnt++;
        total_cnt++; if (errs_reg != 0) $display("FAIL rand_regs_total got=%0d exp=0", errs_reg); else pass_cnt++;
        total_cnt++; if (errs_sb != 0) $display("FAIL rand_sb_total got=%0d exp=0", errs_sb); else pass_cnt++;
        total_cnt++; if (errs_stable != 0) $display("FAIL rand_stable_total got=%0d exp=0", errs_stable); else pass_cnt++;
        total_cnt++; if (max_wait > 3) $display("FAIL rand_starve got=%0d exp<=3", max_wait); else pass_cnt++;
        total_cnt++; if (sb.size() > 1) $display("FAIL rand_sb_left got=%0d exp<=1", sb.size()); else pass_cnt++;
    endtask

    initial begin
        req        = 4'b0000;
        dout_ready = 1'b0;
        rst_n      = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        test_reset();
        test_alternate();
        test_all_four();
        test_stall();
        test_drain();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which sets the width of every data port.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  4  per-requester valid; bit i means din_i holds a word.
REQ-006 din0..din3  input  WIDTH each  requester data words.
REQ-007 ack  output  4  combinational one-hot; ack[i] high means din_i is captured at this clock edge.
REQ-008 sel  output  2  registered index of the word currently held at dout; drives external mux/steering.
REQ-009 dout  output  WIDTH  registered granted word.
REQ-010 dout_valid  output  1  dout holds an unconsumed word.
REQ-011 dout_ready  input  1  consumer accepts dout when dout_valid is also high.
REQ-012 busy  output  1  equals dout_valid; provided for status.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (dout_valid=0) and FULL (dout_valid=1).
REQ-014 A capture opportunity SHALL exist in IDLE, or in FULL while dout_ready=1.
REQ-015 At a capture opportunity with req!=0, the winner SHALL be the first set req bit searching circularly from ptr+1 (mod 4).
REQ-016 At a capture, ack SHALL be high only for the winner's bit.
REQ-017 At the capturing edge: dout<=din_winner, sel<=winner, ptr<=winner, dout_valid<=1, state<=FULL.
REQ-018 In FULL with dout_ready=1 and req==0: dout_valid<=0, state<=IDLE; dout, sel and ptr SHALL hold.
REQ-019 In FULL with dout_ready=0: all registers SHALL hold, ack SHALL be 0, and dout and sel SHALL be stable.
REQ-020 Consume and capture in the same cycle SHALL sustain one word per cycle with no bubble.
REQ-021 ack SHALL be 0 whenever req==0 or no capture opportunity exists.
REQ-022 The round-robin rule SHALL guarantee that, with all four requesting, each requester waits at most 3 other captures.
REQ-023 A lone persistent requester SHALL win every opportunity.
REQ-024 Latency from req to dout_valid SHALL be 1 cycle from IDLE.
REQ-025 Requesters SHALL hold din_i stable while req[i]=1 and ack[i]=0.
REQ-026 req dropping without ack SHALL be legal and SHALL not disturb state.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, dout_valid=0, busy=0, dout=0, sel=0 and ptr=3, so requester 0 has first priority.
REQ-028 ack SHALL be 0 while rst_n=0.
REQ-029 Reset mid-FULL SHALL discard the held word; the first capture after release SHALL again favour requester 0.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration, the requester count (4) and the index width (2).
REQ-031 The combinational circular priority pick (inputs req and ptr; outputs winner index and any-valid) SHALL be the sub-module rr_pick4.
REQ-032 Data selection SHALL instantiate the existing mux4to1 with s=winner index.
REQ-033 Total RTL SHALL be 120-400 lines.

Verification
REQ-034 Release reset, then req=4'b0101, din0=8'h11, din2=8'h22, dout_ready=1 -> captures in order 0,2,0,2; dout sequence 11,22,11,22 on consecutive cycles; ack alternates 0001/0100.
REQ-035 req=4'b1111, dout_ready=1, hold 8 cycles -> sel sequence 0,1,2,3,0,1,2,3; no bubble.
REQ-036 Capture din1=8'hA5, then dout_ready=0 for 5 cycles with req=4'b1111 -> dout=A5, sel=1, ack=0 throughout; on ready=1, the next capture is requester 2.
REQ-037 Single word from requester 3, then req=0 with ready=1 -> dout_valid falls after 1 cycle; sel holds 3; the next req=4'b1001 grants 0.
REQ-038 Assert rst_n=0 mid-FULL asynchronously between edges -> dout_valid=0 before the next edge; after release, req=4'b1010 grants 1 first.
REQ-039 Random req/ready for 10k cycles -> scoreboard confirms: each acked word appears once, in order; no requester starved beyond 3 captures; dout stable while valid&&!ready.
